// File: rtl/booth_pp_decoder.sv
// Radix-4 Booth partial-product generator: selects 0/y/2y, optionally negates,
// and registers the W-bit result with a valid flag.
module booth_pp_decoder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [2:0]   sdn,
    input  logic [W-1:0] y,
    output logic         out_valid,
    output logic [W-1:0] pp
);

    logic [W:0]   p;
    logic [W-1:0] ppn;
    logic [W:0]   seen_one;
    logic [W-1:0] res;

    logic [W-1:0] pp_q, pp_d;
    logic         valid_q, valid_d;

    assign p = {y, 1'b0};

    // Bitwise select: 11x codes OR y and 2y together rather than adding them.
    always_comb begin
        ppn = '0;
        for (int unsigned j = 0; j < W; j++) begin
            ppn[j] = (sdn[1] & p[j]) | (sdn[2] & p[j+1]);
        end
    end

    // Two's-complement negation without a carry chain: keep bits up to and
    // including the lowest set bit, invert everything above it.
    always_comb begin
        seen_one    = '0;
        res         = '0;
        for (int unsigned j = 0; j < W; j++) begin
            res[j]        = ppn[j] ^ (sdn[0] & seen_one[j]);
            seen_one[j+1] = seen_one[j] | ppn[j];
        end
    end

    always_comb begin
        valid_d = in_valid;
        pp_d    = pp_q;
        if (in_valid) begin
            pp_d = res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            pp_q    <= pp_d;
            valid_q <= valid_d;
        end
    end

    assign pp        = pp_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_booth_pp_decoder.sv
// Scoreboard bench for booth_pp_decoder: driver pushes expected register state,
// monitor pops and compares one entry per cycle.
module tb_booth_pp_decoder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         v;
        logic [W-1:0] pp;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [2:0]   sdn;
    logic [W-1:0] y;
    logic         out_valid;
    logic [W-1:0] pp;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;
    logic [W-1:0] model_pp;

    booth_pp_decoder #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sdn      (sdn),
        .y        (y),
        .out_valid(out_valid),
        .pp       (pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: selected magnitude by plain arithmetic, negated modulo 2^W.
    function automatic logic [W-1:0] ref_pp(input logic [2:0] s, input logic [W-1:0] yy);
        int unsigned m, sel, r;
        m   = 1 << W;
        sel = 0;
        if (s[2]) sel = sel | int'(yy);
        if (s[1]) sel = sel | ((int'(yy) * 2) % m);
        r = s[0] ? (m - sel) % m : sel;
        return r[W-1:0];
    endfunction

    task automatic step(input logic r, input logic v, input logic [2:0] s,
                        input logic [W-1:0] yy);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        sdn      = s;
        y        = yy;
        @(posedge clk);
        if (r) begin
            model_pp = '0;
            e.v      = 1'b0;
        end else begin
            if (v) model_pp = ref_pp(s, yy);
            e.v = v;
        end
        e.pp = model_pp;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (out_valid !== e.v) begin
                n_bad++;
                $display("FAIL out_valid: got %b want %b (t=%0t)", out_valid, e.v, $time);
            end
            n_vec++;
            if (pp !== e.pp) begin
                n_bad++;
                $display("FAIL pp: got %h want %h (t=%0t)", pp, e.pp, $time);
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        model_pp = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        sdn      = '0;
        y        = '0;

        step(1'b1, 1'b1, 3'b100, 8'h0F);
        step(1'b1, 1'b1, 3'b100, 8'h0F);

        step(1'b0, 1'b1, 3'b100, 8'h0B);
        step(1'b0, 1'b1, 3'b010, 8'h0B);
        step(1'b0, 1'b1, 3'b000, 8'h0B);
        step(1'b0, 1'b1, 3'b101, 8'h0B);
        step(1'b0, 1'b1, 3'b011, 8'h0B);
        step(1'b0, 1'b1, 3'b001, 8'h0B);
        step(1'b0, 1'b1, 3'b010, 8'hC1);
        step(1'b0, 1'b1, 3'b011, 8'h80);
        step(1'b0, 1'b1, 3'b110, 8'h0A);
        step(1'b0, 1'b1, 3'b111, 8'h0A);
        step(1'b0, 1'b0, 3'b100, 8'h33);
        step(1'b0, 1'b1, 3'b111, 8'hFF);
        step(1'b0, 1'b1, 3'b101, 8'h01);

        for (int i = 0; i < 200; i++) begin
            logic         v;
            logic [2:0]   s;
            logic [W-1:0] yy;
            v  = ($urandom_range(0, 9) != 0);
            s  = 3'($urandom_range(0, 5));
            yy = W'($urandom_range(8, 15));
            step(1'b0, v, s, yy);
        end

        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), W'($urandom));
        end

        step(1'b1, 1'b1, 3'b100, 8'h55);
        step(1'b0, 1'b0, 3'b000, 8'h00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
